dpram_copy_engine: RTL and testbench
====================================

# dpram_copy_engine

Sequential block-copy engine that drives the dual-port RAM (`dram`) from the other side. It reads a contiguous block through RAM port 1 and writes it to a destination block through RAM port 2 at one word per clock. It replaces hand-driven `w1/addr1/d1` and `w2/addr2/d2` stimulus with a start/busy/done handshake, and sits between a host controller and the RAM.

## Interface

Parameters:
- `DW`, 8: data width; matches RAM `d1/d2/dout1/dout2`.
- `AW`, 8: address width; matches RAM `addr1/addr2`.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `start`  in  1  request a copy; sampled only in IDLE.
- `abort`  in  1  cancel an active copy; ignored in IDLE.
- `src_addr`  in  AW  first source address; latched on accepted `start`.
- `dst_addr`  in  AW  first destination address; latched on accepted `start`.
- `len`  in  AW+1  number of words, 0..2^AW; latched on accepted `start`.
- `busy`  out  1  high while a copy is in progress.
- `done`  out  1  one-cycle pulse when a copy completes normally.
- `aborted`  out  1  one-cycle pulse when a copy is cancelled.
- `rd_we`  out  1  RAM port-1 write enable; constant 0.
- `rd_addr`  out  AW  RAM port-1 address.
- `rd_data`  in  DW  RAM port-1 read data; valid one cycle after `rd_addr` is presented.
- `wr_we`  out  1  RAM port-2 write enable.
- `wr_addr`  out  AW  RAM port-2 address.
- `wr_data`  out  DW  RAM port-2 write data.

## Operation

- States are IDLE, RUN, DRAIN and FIN.
- IDLE:
  - `start=1` latches `src_addr`, `dst_addr` and `len`, and clears the read counter `rc`.
  - If `len=0`, go to FIN; otherwise go to RUN.
- RUN:
  - Each cycle, present `rd_addr = src + rc` (mod 2^AW) and increment `rc`.
  - When `rc` reaches `len-1` in this cycle, go to DRAIN.
- Write pipeline:
  - A one-stage valid/address register follows each read.
  - In the cycle after read k, drive `wr_we=1`, `wr_addr = dst + k` (mod 2^AW) and `wr_data = rd_data`.
  - `wr_data` is passed through combinationally from `rd_data`; there is no extra register.
- DRAIN: issues the final write (k = len-1), then goes to FIN.
- FIN: `done=1` for one cycle, then go to IDLE.
- Address wrap:
  - Source and destination addresses wrap modulo 2^AW independently.
  - `len = 2^AW` copies the whole memory.
- Abort:
  - `abort=1` in RUN or DRAIN ends the copy on that edge.
  - No further reads or writes are issued, and any in-flight write is dropped (`wr_we=0` from the next cycle).
  - The engine pulses `aborted` for one cycle, then returns to IDLE.
  - If `abort` arrives in the same cycle FIN is entered, `done` takes priority and `abort` is ignored.
- `start` while `busy=1` is ignored. `start` and `abort` together in IDLE: the copy starts.
- Overlap:
  - The result is defined only if no destination word lies in [src+k+1, src+len-1] when it is written. Forward copy with dst ≤ src, and non-overlapping blocks, are always correct.
  - Otherwise, RAM contents are undefined but the timing is unchanged.
- Reset:
  - All outputs go to 0, all address/data outputs to 0, and the state to IDLE.
  - A copy interrupted by `rst` leaves the RAM partially written; no `done` is generated.

## Timing

- Cycle 0 is the edge that samples `start`.
- `busy` is high in cycles 1..len+1.
- Reads are issued in cycles 1..len; writes in cycles 2..len+1.
- `done` is high in cycle len+2, and `busy` is 0 in that cycle.
- A new `start` is accepted in cycle len+3.
- `len=0`: `busy` is 0, no RAM access occurs, and `done` is high in cycle 1.
- Throughput is 1 word per cycle with no bubbles.
- Abort sampled at edge t: `aborted=1` in cycle t+1; no `wr_we` after cycle t.

## Test plan

- **Basic copy:** preload RAM[1..4] = 01, 02, 03, 04; start with src=1, dst=0x40, len=4 → `wr_we` in cycles 2..5, RAM[0x40..0x43] = 01..04, `done` in cycle 6.
- **Zero length:** start with len=0 → `done` in cycle 1, `busy` never 1, `rd_addr`/`wr_we` unchanged.
- **Wrap:** src=0xFE, dst=0x10, len=4 → reads at FE, FF, 00, 01; RAM[0x10..0x13] equals the preloaded values.
- **Abort:** len=8, assert `abort` at cycle 4 → exactly 3 words written (cycles 2..4), `aborted` in cycle 5, no `done`, IDLE afterwards.
- **Ignored start:** pulse `start` with new parameters at cycle 3 of a len=5 copy → original copy unaffected, single `done` in cycle 7.
- **Reset mid-copy:** assert `rst` at cycle 3 → all outputs 0 the next cycle; a subsequent `start` copies correctly.

Source files
------------

// File: rtl/dpram_copy_engine.sv
// Block-copy engine: streams a source block from RAM port 1 into a
// destination block on RAM port 2 at one word per clock.
module dpram_copy_engine #(
   parameter int DW = 8,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [AW-1:0] src_addr,
   input  logic [AW-1:0] dst_addr,
   input  logic [AW:0]   len,
   output logic          busy,
   output logic          done,
   output logic          aborted,
   output logic          rd_we,
   output logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] rd_data,
   output logic          wr_we,
   output logic [AW-1:0] wr_addr,
   output logic [DW-1:0] wr_data
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

   state_t        state;
   logic [AW-1:0] src;
   logic [AW-1:0] wptr;
   logic [AW:0]   rc;
   logic [AW:0]   n;

   assign rd_we   = 1'b0;
   // Read data arrives exactly in the write cycle, so no staging register.
   assign wr_data = wr_we ? rd_data : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         aborted <= 1'b0;
         rd_addr <= '0;
         wr_we   <= 1'b0;
         wr_addr <= '0;
         src     <= '0;
         wptr    <= '0;
         rc      <= '0;
         n       <= '0;
      end else begin
         done    <= 1'b0;
         aborted <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  src  <= src_addr;
                  wptr <= dst_addr;
                  n    <= len;
                  // read 0 is issued on this edge; rc counts the next one
                  rc   <= {{AW{1'b0}}, 1'b1};
                  if (len == '0) begin
                     state <= FIN;
                     done  <= 1'b1;
                  end else begin
                     state   <= RUN;
                     busy    <= 1'b1;
                     rd_addr <= src_addr;
                  end
               end
            end
            RUN: begin
               if (abort) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  wr_we   <= 1'b0;
                  aborted <= 1'b1;
               end else begin
                  wr_we   <= 1'b1;
                  wr_addr <= wptr;
                  wptr    <= wptr + 1'b1;
                  if (rc == n) begin
                     state <= DRAIN;
                  end else begin
                     rd_addr <= src + rc[AW-1:0];
                     rc      <= rc + 1'b1;
                  end
               end
            end
            DRAIN: begin
               // final write is on the bus now; completion wins over abort
               state <= FIN;
               wr_we <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            FIN: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dpram_copy_engine.sv
// Directed bench for dpram_copy_engine with a behavioural dual-port RAM.
// Per-cycle activity is logged as bit vectors indexed by cycle number.
module tb_dpram_copy_engine;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] src_addr = '0;
   logic [7:0] dst_addr = '0;
   logic [8:0] len = '0;
   logic       busy, done, aborted, rd_we, wr_we;
   logic [7:0] rd_addr, wr_addr, wr_data;
   logic [7:0] rd_data;

   logic [7:0] mem [256];
   logic       pre_we = 1'b0;
   logic [7:0] pre_a = '0;
   logic [7:0] pre_d = '0;

   int nchk = 0;
   int nfail = 0;

   logic [15:0] busy_v, done_v, we_v, ab_v;
   logic [7:0]  ra [16];
   logic [7:0]  wa [16];
   logic [7:0]  wd [16];

   always #5 clk = ~clk;

   dpram_copy_engine #(.DW(8), .AW(8)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
      .busy(busy), .done(done), .aborted(aborted),
      .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_we(wr_we), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   always @(posedge clk) begin
      rd_data <= mem[rd_addr];
      if (pre_we) mem[pre_a] <= pre_d;
      else if (wr_we) mem[wr_addr] <= wr_data;
   end

   task automatic pre(input logic [7:0] a, input logic [7:0] d);
      pre_a = a; pre_d = d; pre_we = 1'b1;
      @(posedge clk); #1;
      pre_we = 1'b0;
   endtask

   // Start a copy before edge 0 and log cycles 1..15; optional abort,
   // stray start pulse or reset are asserted during the given cycle.
   task automatic go(input logic [7:0] s, input logic [7:0] d,
                     input logic [8:0] l, input int ab_c,
                     input int st_c, input int rs_c);
      src_addr = s; dst_addr = d; len = l; start = 1'b1;
      busy_v = '0; done_v = '0; we_v = '0; ab_v = '0;
      for (int c = 1; c < 16; c++) begin
         @(posedge clk); #1;
         start = 1'b0; abort = 1'b0; rst = 1'b0;
         busy_v[c] = busy; done_v[c] = done;
         we_v[c] = wr_we; ab_v[c] = aborted;
         ra[c] = rd_addr; wa[c] = wr_addr; wd[c] = wr_data;
         if (c == ab_c) abort = 1'b1;
         if (c == st_c) begin
            start = 1'b1; src_addr = 8'h00; dst_addr = 8'h00; len = 9'd2;
         end
         if (c == rs_c) rst = 1'b1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      nchk++;
      if ({busy, done, aborted, rd_we, wr_we} !== 5'b0) begin
         nfail++;
         $display("FAIL reset_flags got=%b exp=00000",
                  {busy, done, aborted, rd_we, wr_we});
      end
      nchk++;
      if ({rd_addr, wr_addr, wr_data} !== 24'h0) begin
         nfail++;
         $display("FAIL reset_addr got=%h exp=000000",
                  {rd_addr, wr_addr, wr_data});
      end
   endtask

   task automatic test_basic;
      for (int i = 1; i <= 4; i++) pre(8'(i), 8'(i));
      for (int i = 0; i < 4; i++) pre(8'h40 + 8'(i), 8'hEE);
      go(8'h01, 8'h40, 9'd4, 0, 0, 0);
      nchk++;
      if (busy_v !== 16'h003E) begin
         nfail++; $display("FAIL basic_busy got=%h exp=003E", busy_v);
      end
      nchk++;
      if (we_v !== 16'h003C) begin
         nfail++; $display("FAIL basic_we got=%h exp=003C", we_v);
      end
      nchk++;
      if (done_v !== 16'h0040) begin
         nfail++; $display("FAIL basic_done got=%h exp=0040", done_v);
      end
      nchk++;
      if (ra[1] !== 8'h01 || ra[4] !== 8'h04) begin
         nfail++;
         $display("FAIL basic_rdaddr got=%h,%h exp=01,04", ra[1], ra[4]);
      end
      nchk++;
      if (wa[2] !== 8'h40 || wd[2] !== 8'h01 || wa[5] !== 8'h43) begin
         nfail++;
         $display("FAIL basic_wr got=%h/%h,%h exp=40/01,43",
                  wa[2], wd[2], wa[5]);
      end
      for (int i = 0; i < 4; i++) begin
         nchk++;
         if (mem[8'h40 + 8'(i)] !== 8'(i + 1)) begin
            nfail++;
            $display("FAIL basic_mem[%0d] got=%h exp=%h", i,
                     mem[8'h40 + 8'(i)], 8'(i + 1));
         end
      end
   endtask

   task automatic test_wrap;
      pre(8'hFE, 8'hA0); pre(8'hFF, 8'hA1);
      pre(8'h00, 8'hA2); pre(8'h01, 8'hA3);
      go(8'hFE, 8'h10, 9'd4, 0, 0, 0);
      nchk++;
      if ({ra[1], ra[2], ra[3], ra[4]} !== 32'hFEFF0001) begin
         nfail++;
         $display("FAIL wrap_rd got=%h exp=FEFF0001",
                  {ra[1], ra[2], ra[3], ra[4]});
      end
      nchk++;
      if ({mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}
          !== 32'hA0A1A2A3) begin
         nfail++;
         $display("FAIL wrap_mem got=%h exp=A0A1A2A3",
                  {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]});
      end
   endtask

   task automatic test_zero_len;
      go(8'h55, 8'h66, 9'd0, 0, 0, 0);
      nchk++;
      if (done_v !== 16'h0002) begin
         nfail++; $display("FAIL zero_done got=%h exp=0002", done_v);
      end
      nchk++;
      if (busy_v !== 16'h0 || we_v !== 16'h0) begin
         nfail++;
         $display("FAIL zero_busy_we got=%h/%h exp=0/0", busy_v, we_v);
      end
      nchk++;
      if (ra[1] !== 8'h01 || ra[3] !== 8'h01) begin
         nfail++;
         $display("FAIL zero_rdaddr got=%h,%h exp=01,01", ra[1], ra[3]);
      end
   endtask

   task automatic test_abort;
      for (int i = 0; i < 8; i++) begin
         pre(8'h20 + 8'(i), 8'hB0 + 8'(i));
         pre(8'h80 + 8'(i), 8'h00);
      end
      go(8'h20, 8'h80, 9'd8, 4, 0, 0);
      nchk++;
      if (we_v !== 16'h001C) begin
         nfail++; $display("FAIL abort_we got=%h exp=001C", we_v);
      end
      nchk++;
      if (ab_v !== 16'h0020 || done_v !== 16'h0) begin
         nfail++;
         $display("FAIL abort_pulse got=%h/%h exp=0020/0000", ab_v, done_v);
      end
      nchk++;
      if (busy_v !== 16'h001E) begin
         nfail++; $display("FAIL abort_busy got=%h exp=001E", busy_v);
      end
      nchk++;
      if ({mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83]}
          !== 32'hB0B1B200) begin
         nfail++;
         $display("FAIL abort_mem got=%h exp=B0B1B200",
                  {mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83]});
      end
   endtask

   task automatic test_ignored_start;
      for (int i = 0; i < 5; i++) pre(8'h30 + 8'(i), 8'hC0 + 8'(i));
      go(8'h30, 8'h90, 9'd5, 0, 3, 0);
      nchk++;
      if (done_v !== 16'h0080) begin
         nfail++; $display("FAIL ign_done got=%h exp=0080", done_v);
      end
      nchk++;
      if (busy_v !== 16'h007E || we_v !== 16'h007C) begin
         nfail++;
         $display("FAIL ign_busy_we got=%h/%h exp=007E/007C", busy_v, we_v);
      end
      nchk++;
      if ({mem[8'h90], mem[8'h92], mem[8'h94]} !== 24'hC0C2C4) begin
         nfail++;
         $display("FAIL ign_mem got=%h exp=C0C2C4",
                  {mem[8'h90], mem[8'h92], mem[8'h94]});
      end
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 6; i++) pre(8'h50 + 8'(i), 8'hD0 + 8'(i));
      go(8'h50, 8'hA0, 9'd6, 0, 0, 3);
      nchk++;
      if (busy_v !== 16'h000E || we_v !== 16'h000C || done_v !== 16'h0) begin
         nfail++;
         $display("FAIL rstmid_act got=%h/%h/%h exp=000E/000C/0000",
                  busy_v, we_v, done_v);
      end
      nchk++;
      if (ra[4] !== 8'h00 || wa[4] !== 8'h00 || wd[4] !== 8'h00) begin
         nfail++;
         $display("FAIL rstmid_zero got=%h/%h/%h exp=00/00/00",
                  ra[4], wa[4], wd[4]);
      end
      go(8'h50, 8'hB0, 9'd3, 0, 0, 0);
      nchk++;
      if (done_v !== 16'h0020) begin
         nfail++; $display("FAIL rstmid_done got=%h exp=0020", done_v);
      end
      nchk++;
      if ({mem[8'hB0], mem[8'hB1], mem[8'hB2]} !== 24'hD0D1D2) begin
         nfail++;
         $display("FAIL rstmid_mem got=%h exp=D0D1D2",
                  {mem[8'hB0], mem[8'hB1], mem[8'hB2]});
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_zero_len();
      test_abort();
      test_ignored_start();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

endmodule
